// File: rtl/wb_flash_prefetch_pkg.sv
// Shared types and defaults for the flash read line buffer.
package wb_flash_prefetch_pkg;

    localparam int LINE_WORDS_DEF = 4;
    localparam int FLASH_AW_DEF   = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_GAP,
        ST_RESP,
        ST_PASS,
        ST_ACK
    } state_e;

endpackage

// File: rtl/wb_flash_prefetch_if.sv
// Classic Wishbone bundle, used on both the CPU and flash sides.
interface wb_flash_prefetch_if;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, adr, sel, we, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, adr, sel, we, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_flash_prefetch_line_ram.sv
// Line buffer storage: one write port, one asynchronous read port.
module wb_flash_prefetch_line_ram #(
    parameter int WORDS = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/wb_flash_prefetch.sv
// Read line buffer between the CPU Wishbone master and the flash slave.
module wb_flash_prefetch
    import wb_flash_prefetch_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int FLASH_AW   = FLASH_AW_DEF
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    wb_flash_prefetch_if.slave   s,
    wb_flash_prefetch_if.master  m,
    input  logic                 inv_i
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int TAG_W = FLASH_AW - IDX_W - 2;

    state_e             state_q, state_d;
    logic [31:0]        req_adr, req_dat;
    logic [3:0]         req_sel;
    logic               req_we;
    logic [TAG_W-1:0]   tag_q;
    logic               line_valid, inv_seen;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        dat_q;
    logic               ack_q, err_q;
    logic [IDX_W-1:0]   ridx;
    logic [31:0]        rdata;
    logic               req, rd_full, hit, wr_hit, ram_we;

    assign req     = s.cyc & s.stb;
    assign rd_full = ~s.we & (s.sel == 4'hF);
    assign hit     = req & rd_full & line_valid &
                     (s.adr[FLASH_AW-1:IDX_W+2] == tag_q);
    assign wr_hit  = req_we & line_valid &
                     (req_adr[FLASH_AW-1:IDX_W+2] == tag_q);
    assign ridx    = (state_q == ST_IDLE) ? s.adr[IDX_W+1:2]
                                          : req_adr[IDX_W+1:2];
    assign ram_we  = (state_q == ST_FILL) & m.ack & ~m.err;

    assign s.dat_r = dat_q;
    assign s.ack   = ack_q;
    assign s.err   = err_q;

    wb_flash_prefetch_line_ram #(
        .WORDS (LINE_WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (wb_clk_i),
        .we    (ram_we),
        .widx  (idx),
        .wdata (m.dat_r),
        .ridx  (ridx),
        .rdata (rdata)
    );

    always_comb begin
        state_d = state_q;
        m.cyc   = 1'b0;
        m.stb   = 1'b0;
        m.adr   = '0;
        m.sel   = '0;
        m.we    = 1'b0;
        m.dat_w = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit)          state_d = ST_ACK;
                else if (req)     state_d = rd_full ? ST_FILL : ST_PASS;
            end
            ST_FILL: begin
                m.cyc = 1'b1;
                m.stb = 1'b1;
                m.sel = 4'hF;
                m.adr = {req_adr[31:IDX_W+2], idx, 2'b00};
                if (m.err)        state_d = ST_ACK;
                else if (m.ack)   state_d = ST_GAP;
            end
            // Flash controller re-samples stb only from its own idle state
            ST_GAP: begin
                m.cyc   = 1'b1;
                state_d = (idx == '0) ? ST_RESP : ST_FILL;
            end
            ST_RESP: state_d = ST_ACK;
            ST_PASS: begin
                m.cyc   = 1'b1;
                m.stb   = 1'b1;
                m.adr   = req_adr;
                m.sel   = req_sel;
                m.we    = req_we;
                m.dat_w = req_dat;
                if (m.ack | m.err) state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_IDLE;
            req_adr    <= '0;
            req_dat    <= '0;
            req_sel    <= '0;
            req_we     <= 1'b0;
            tag_q      <= '0;
            line_valid <= 1'b0;
            inv_seen   <= 1'b0;
            idx        <= '0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (inv_i) line_valid <= 1'b0;
                    if (req) begin
                        req_adr <= s.adr;
                        req_dat <= s.dat_w;
                        req_sel <= s.sel;
                        req_we  <= s.we;
                    end
                    if (hit) begin
                        dat_q <= rdata;
                        ack_q <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (inv_i) inv_seen <= 1'b1;
                    if (m.err) begin
                        err_q      <= 1'b1;
                        line_valid <= 1'b0;
                        inv_seen   <= 1'b0;
                        idx        <= '0;
                    end else if (m.ack) begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (inv_i) inv_seen <= 1'b1;
                    if (idx == '0) begin
                        line_valid <= ~(inv_seen | inv_i);
                        tag_q      <= req_adr[FLASH_AW-1:IDX_W+2];
                    end
                end
                ST_RESP: begin
                    dat_q    <= rdata;
                    ack_q    <= s.cyc;
                    inv_seen <= 1'b0;
                    if (inv_i) line_valid <= 1'b0;
                end
                ST_PASS: begin
                    if (inv_i) line_valid <= 1'b0;
                    if (m.err) begin
                        err_q      <= 1'b1;
                        line_valid <= 1'b0;
                        idx        <= '0;
                    end else if (m.ack) begin
                        dat_q <= m.dat_r;
                        ack_q <= 1'b1;
                        if (wr_hit) line_valid <= 1'b0;
                    end
                end
                ST_ACK: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (inv_i) line_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_flash_prefetch.sv
// Directed bench for the flash read line buffer with a fixed-latency flash model.
module tb_wb_flash_prefetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inv = 1'b0;
    logic err_inject = 1'b0;

    int n_run = 0;
    int n_fail = 0;
    int ack_cnt = 0;
    int gap_viol = 0;
    logic ack_prev = 1'b0;
    int lat = 0;

    logic [31:0] log_adr [$];
    logic [3:0]  log_sel [$];
    logic        log_we  [$];
    logic [31:0] log_dat [$];

    wb_flash_prefetch_if cpu ();
    wb_flash_prefetch_if flash ();

    wb_flash_prefetch dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .s          (cpu),
        .m          (flash),
        .inv_i      (inv)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] flash_word(input logic [31:0] a);
        return 32'hA0 + (a >> 2) - 32'h40;
    endfunction

    // Flash answers 2 cycles after it first sees stb (3 cycles of stb)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash.ack   <= 1'b0;
            flash.err   <= 1'b0;
            flash.dat_r <= '0;
            lat         <= 0;
        end else begin
            flash.ack <= 1'b0;
            flash.err <= 1'b0;
            if (flash.cyc && flash.stb && !flash.ack && !flash.err) begin
                if (lat == 1) begin
                    lat <= 0;
                    if (err_inject) flash.err <= 1'b1;
                    else begin
                        flash.ack   <= 1'b1;
                        flash.dat_r <= flash_word(flash.adr);
                    end
                end else begin
                    lat <= lat + 1;
                end
            end else begin
                lat <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cpu.ack) ack_cnt++;
        if (ack_prev && flash.stb) gap_viol++;
        ack_prev = flash.ack;
        if (flash.ack) begin
            log_adr.push_back(flash.adr);
            log_sel.push_back(flash.sel);
            log_we.push_back(flash.we);
            log_dat.push_back(flash.dat_w);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [3:0] sel,
                        input logic we, input logic [31:0] wd,
                        output logic [31:0] rd, output int n,
                        output logic ak, output logic er);
        @(negedge clk);
        cpu.cyc = 1'b1;
        cpu.stb = 1'b1;
        cpu.adr = a;
        cpu.sel = sel;
        cpu.we = we;
        cpu.dat_w = wd;
        n = 0;
        ak = 1'b0;
        er = 1'b0;
        while (!ak && !er && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            ak = cpu.ack;
            er = cpu.err;
        end
        rd = cpu.dat_r;
        cpu.cyc = 1'b0;
        cpu.stb = 1'b0;
        cpu.we = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic rd_chk(input string t, input logic [31:0] a,
                          input logic [31:0] exp_d, input int exp_cyc,
                          input int exp_fetch);
        int b, ab, n;
        logic [31:0] d;
        logic ak, er;
        b = log_adr.size();
        ab = ack_cnt;
        xfer(a, 4'hF, 1'b0, '0, d, n, ak, er);
        check({t, "_dat"}, d, exp_d);
        check({t, "_cyc"}, n, exp_cyc);
        check({t, "_fetch"}, log_adr.size() - b, exp_fetch);
        check({t, "_acks"}, ack_cnt - ab, 1);
        if (exp_fetch == 4 && log_adr.size() >= b + 4) begin
            check({t, "_adr0"}, log_adr[b], {a[31:4], 4'h0});
            check({t, "_adr3"}, log_adr[b+3], {a[31:4], 4'hC});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int n, b, ab;
        logic ak, er;
        cpu.cyc = 1'b0;
        cpu.stb = 1'b0;
        cpu.adr = '0;
        cpu.sel = '0;
        cpu.we = 1'b0;
        cpu.dat_w = '0;

        repeat (3) @(negedge clk);
        check("rst_ack", cpu.ack, 0);
        check("rst_err", cpu.err, 0);
        check("rst_dat", cpu.dat_r, 0);
        check("rst_mcyc", flash.cyc, 0);
        check("rst_mstb", flash.stb, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        rd_chk("t1_cold", 32'h100, 32'hA0, 18, 4);
        if (log_adr.size() >= 4) begin
            check("t1_adr1", log_adr[1], 32'h104);
            check("t1_adr2", log_adr[2], 32'h108);
        end

        rd_chk("t2_hit", 32'h108, 32'hA2, 1, 0);
        rd_chk("t2_hit3", 32'h10C, 32'hA3, 1, 0);
        rd_chk("t2_newline", 32'h110, 32'hA4, 18, 4);

        rd_chk("t3_fill", 32'h100, 32'hA0, 18, 4);
        b = log_adr.size();
        xfer(32'h104, 4'hF, 1'b1, 32'h00FF00FF, d, n, ak, er);
        check("t3_wr_ack", ak, 1);
        check("t3_wr_cyc", n, 4);
        check("t3_wr_fetch", log_adr.size() - b, 1);
        if (log_adr.size() > b) begin
            check("t3_wr_adr", log_adr[b], 32'h104);
            check("t3_wr_we", log_we[b], 1);
            check("t3_wr_dat", log_dat[b], 32'h00FF00FF);
        end
        rd_chk("t3_reread", 32'h104, 32'hA1, 18, 4);

        b = log_adr.size();
        xfer(32'h102, 4'b0011, 1'b0, '0, d, n, ak, er);
        check("t4_ack", ak, 1);
        check("t4_cyc", n, 4);
        check("t4_dat", d, 32'hA0);
        check("t4_fetch", log_adr.size() - b, 1);
        if (log_adr.size() > b) begin
            check("t4_sel", log_sel[b], 4'b0011);
            check("t4_adr", log_adr[b], 32'h102);
        end
        rd_chk("t4_hit", 32'h108, 32'hA2, 1, 0);

        b = log_adr.size();
        fork
            rd_chk("t5_inv", 32'h200, 32'hE0, 18, 4);
            begin
                for (int i = 0; i < 300 && log_adr.size() < b + 1; i++)
                    @(negedge clk);
                inv = 1'b1;
                @(negedge clk);
                inv = 1'b0;
            end
        join
        rd_chk("t5_refetch", 32'h200, 32'hE0, 18, 4);
        rd_chk("t5_hit", 32'h204, 32'hE1, 1, 0);
        @(negedge clk);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        rd_chk("t5_idle_inv", 32'h208, 32'hE2, 18, 4);
        fork
            rd_chk("t5_inv_hit", 32'h20C, 32'hE3, 1, 0);
            begin
                @(negedge clk);
                inv = 1'b1;
                @(negedge clk);
                inv = 1'b0;
            end
        join
        rd_chk("t5_after_hit", 32'h20C, 32'hE3, 18, 4);

        err_inject = 1'b1;
        ab = ack_cnt;
        xfer(32'h300, 4'hF, 1'b0, '0, d, n, ak, er);
        err_inject = 1'b0;
        check("t6_err", er, 1);
        check("t6_noack", ack_cnt - ab, 0);
        check("t6_cyc", n, 4);
        rd_chk("t6_after_err", 32'h20C, 32'hE3, 18, 4);

        b = log_adr.size();
        ab = ack_cnt;
        @(negedge clk);
        cpu.cyc = 1'b1;
        cpu.stb = 1'b1;
        cpu.adr = 32'h100;
        cpu.sel = 4'hF;
        cpu.we = 1'b0;
        for (int i = 0; i < 300 && log_adr.size() < b + 2; i++)
            @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t7_mcyc", flash.cyc, 0);
        check("t7_mstb", flash.stb, 0);
        check("t7_madr", flash.adr, 0);
        check("t7_ack", cpu.ack, 0);
        check("t7_dat", cpu.dat_r, 0);
        cpu.cyc = 1'b0;
        cpu.stb = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("t7_noack", ack_cnt - ab, 0);
        repeat (2) @(negedge clk);
        rd_chk("t7_refill", 32'h100, 32'hA0, 18, 4);

        check("stb_gap", gap_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
